// File: rtl/card_pkg.sv
// Shared constants and helpers for the memory-card game datapath.
// Phase codes mirror the control FSM strobes seen by the datapath.
package card_pkg;

  localparam int CARD_W_DEF  = 3;
  localparam int SCORE_W_DEF = 4;

  // Fibonacci taps 8,6,5,4 as a mask over state bits [7:0]
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  localparam logic [1:0] P_IDLE  = 2'd0;
  localparam logic [1:0] P_ONE   = 2'd1;
  localparam logic [1:0] P_TWO   = 2'd2;
  localparam logic [1:0] P_JUDGE = 2'd3;

  function automatic logic [1:0] phase_dec(
    input logic nco,
    input logic oca,
    input logic an
  );
    logic [1:0] p;
    p = P_IDLE;
    unique case (1'b1)
      an:               p = P_JUDGE;
      !an & nco & !oca: p = P_ONE;
      !an & nco & oca:  p = P_TWO;
      default:          p = P_IDLE;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] lfsr_step(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 8-bit Fibonacci LFSR with seed and enable.
// Exposes the low OUT_W bits plus the MSB used as a coin flip.
module card_lfsr
  import card_pkg::*;
#(
  parameter logic [7:0] SEED  = 8'hA5,
  parameter int         OUT_W = 3
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  output logic [OUT_W-1:0] rnd,
  output logic             msb
);

  logic [7:0] q_q;

  always_ff @(posedge clk) begin
    if (!resetn)
      q_q <= SEED;
    else if (en)
      q_q <= lfsr_step(q_q);
  end

  assign rnd = q_q[OUT_W-1:0];
  assign msb = q_q[7];

endmodule

// File: rtl/card_datapath.sv
// Card game datapath: draws cards, times phases, latches answers,
// judges them against the previous card and tracks scores.
module card_datapath
  import card_pkg::*;
#(
  parameter int         CARD_W      = CARD_W_DEF,
  parameter int         SCORE_W     = SCORE_W_DEF,
  parameter int         TIMEOUT_CYC = 50_000_000,
  parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               next_card_output,
  input  logic               output_correct_answer,
  input  logic               analyse,
  input  logic               key_same,
  input  logic               key_diff,
  output logic               next_card,
  output logic               game_over,
  output logic [CARD_W-1:0]  card_face,
  output logic               card_valid,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [SCORE_W-1:0] S_MAX = '1;

  logic [CARD_W-1:0]  rnd_w;
  logic               msb_w;
  logic [1:0]         phase;
  logic [CARD_W-1:0]  draw;
  logic               match;
  logic               correct;
  logic               key_one;
  logic               tmo;

  logic               next_card_q, next_card_d;
  logic [CARD_W-1:0]  card_face_q, card_face_d;
  logic [CARD_W-1:0]  prev_card_q, prev_card_d;
  logic               in_game_q, in_game_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic               answered_q, answered_d;
  logic               ans_same_q, ans_same_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0] high_q, high_d;

  card_lfsr #(
    .SEED  (LFSR_SEED),
    .OUT_W (CARD_W)
  ) u_lfsr (
    .clk    (clk),
    .resetn (resetn),
    .en     (1'b1),
    .rnd    (rnd_w),
    .msb    (msb_w)
  );

  assign phase   = phase_dec(next_card_output,
                             output_correct_answer, analyse);
  // Holding the face on msb forces a repeat about half the time
  assign draw    = msb_w ? card_face_q : rnd_w;
  assign match   = (card_face_q == prev_card_q);
  assign correct = answered_q & (ans_same_q == match);
  assign key_one = key_same ^ key_diff;
  assign tmo     = (timer_q == T_LAST);

  always_comb begin
    next_card_d = 1'b0;
    card_face_d = card_face_q;
    prev_card_d = prev_card_q;
    in_game_d   = in_game_q;
    timer_d     = '0;
    answered_d  = answered_q;
    ans_same_d  = ans_same_q;
    score_d     = score_q;
    high_d      = high_q;
    if (!in_game_q)
      card_face_d = rnd_w;
    case (phase)
      P_ONE: begin
        if (!in_game_q) begin
          in_game_d = 1'b1;
          score_d   = '0;
        end
        if (!next_card_q) begin
          timer_d = timer_q + 1'b1;
          if (tmo) begin
            next_card_d = 1'b1;
            timer_d     = '0;
            prev_card_d = card_face_q;
            card_face_d = draw;
          end
        end
      end
      P_TWO: begin
        if (!next_card_q) begin
          timer_d = timer_q + 1'b1;
          if (!answered_q) begin
            if (key_one) begin
              answered_d  = 1'b1;
              ans_same_d  = key_same;
              next_card_d = 1'b1;
              timer_d     = '0;
            end else if (tmo) begin
              next_card_d = 1'b1;
              timer_d     = '0;
            end
          end
        end
      end
      P_JUDGE: begin
        answered_d = 1'b0;
        if (correct) begin
          if (score_q != S_MAX)
            score_d = score_q + 1'b1;
          prev_card_d = card_face_q;
          card_face_d = draw;
        end else begin
          if (score_q > high_q)
            high_d = score_q;
          in_game_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      next_card_q <= 1'b0;
      card_face_q <= '0;
      prev_card_q <= '0;
      in_game_q   <= 1'b0;
      timer_q     <= '0;
      answered_q  <= 1'b0;
      ans_same_q  <= 1'b0;
      score_q     <= '0;
      high_q      <= '0;
    end else begin
      next_card_q <= next_card_d;
      card_face_q <= card_face_d;
      prev_card_q <= prev_card_d;
      in_game_q   <= in_game_d;
      timer_q     <= timer_d;
      answered_q  <= answered_d;
      ans_same_q  <= ans_same_d;
      score_q     <= score_d;
      high_q      <= high_d;
    end
  end

  assign next_card  = next_card_q;
  assign game_over  = analyse & ~correct;
  assign card_face  = card_face_q;
  assign card_valid = in_game_q;
  assign score      = score_q;
  assign high_score = high_q;

endmodule

// File: doc/card_datapath.md
Name: card_datapath

Overview:
Datapath partner of the game control FSM in the memory-card game: it consumes the FSM's phase strobes (next_card_output, output_correct_answer, analyse) and produces the FSM's inputs (next_card, game_over). It draws pseudo-random card faces from an LFSR, times the card display, latches the player's same/different answer, and judges it against the previous card. It also keeps the current streak score and the session high score for the display stage.

Parameters:
CARD_W, 3, card face width (2^CARD_W faces)
SCORE_W, 4, score / high-score width, saturating
TIMEOUT_CYC, 50_000_000, card display / answer window in clk cycles (benches use 8)
LFSR_SEED, 8'hA5, LFSR reset value, must be non-zero

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
next_card_output  in  1  FSM: card phase active (CARD_ONE or CARD_TWO)
output_correct_answer  in  1  FSM: answer phase (CARD_TWO) when high together with next_card_output
analyse  in  1  FSM: judge cycle (ANALYZE)
key_same  in  1  player "match" pulse, one cycle, already edge-detected
key_diff  in  1  player "no match" pulse, one cycle, already edge-detected
next_card  out  1  one-cycle registered pulse to the FSM: advance the phase
game_over  out  1  combinational, valid only while analyse=1
card_face  out  CARD_W  current card shown
card_valid  out  1  game in progress; card_face is meaningful
score  out  SCORE_W  correct answers this game
high_score  out  SCORE_W  best score since resetn

Behaviour:
- Reset is synchronous, active-low, on clock clk. On reset: lfsr=LFSR_SEED, next_card=0, card_face=0, prev_card=0, card_valid=0, in_game=0, timer=0, answered=0, ans_same=0, score=0, high_score=0. game_over=0 whenever analyse=0.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, shifts every cycle out of reset.
- Phases are decoded from the inputs: P1 = next_card_output & !output_correct_answer; P2 = next_card_output & output_correct_answer.
- Idle (in_game=0): card_face <= lfsr[CARD_W-1:0] every cycle. The first cycle of P1 sets in_game=1 and clears score; card_face freezes from then on. card_valid = in_game.
- Timer: increments each cycle in P1/P2 while next_card=0, and clears otherwise. The timer clears whenever next_card is issued.
- P1: when timer==TIMEOUT_CYC-1, next_card=1 on the next cycle, i.e. in cycle TIMEOUT_CYC counting the P1 entry cycle as 0. On that pulse edge: prev_card<=card_face and card_face<=draw.
- draw = lfsr[7] ? card_face : lfsr[CARD_W-1:0]. This forces a repeat roughly 50% of the time.
- P2, answered=0:
  - Exactly one of key_same/key_diff high: answered<=1, ans_same<=key_same, next_card=1 on the next cycle.
  - Both keys high: ignored; no latch, no pulse.
  - Timer reaches TIMEOUT_CYC-1 first: next_card=1 with answered=0 (counts as wrong).
  - Keys are ignored outside P2, once answered=1, and during the next_card cycle.
- next_card is never high two consecutive cycles.
- analyse cycle:
  - match = (card_face==prev_card); correct = answered & (ans_same==match); game_over = analyse & !correct.
  - If correct: score <= score+1, saturating at 2^SCORE_W-1. prev_card<=card_face, card_face<=draw, answered<=0.
  - If wrong: high_score<=max(high_score,score), in_game<=0, answered<=0. score holds its value until the next game starts.
- The cycle after analyse (FSM RIGHT/FINISH, all strobes 0) changes no state other than the LFSR.
- Strobes outside the legal FSM sequence (analyse with next_card_output, etc.): analyse takes priority and phase logic is frozen that cycle.
- Reset mid-game returns every register to its reset value in the same edge. A key held on the reset edge is lost.

Decomposition:
- Package card_pkg: CARD_W/SCORE_W defaults, LFSR tap mask, and phase decode constants (P_IDLE, P_ONE, P_TWO, P_JUDGE).
- One sub-module card_lfsr: 8-bit LFSR with seed parameter and enable, reused by later sprite and shuffle blocks.

Test Plan:
- Reset: hold resetn=0 for 2 cycles -> all outputs 0, internal lfsr=8'hA5. Drive analyse=1 with answered=0 -> game_over=1; analyse=0 -> game_over=0.
- Timeout in P1 (TIMEOUT_CYC=8): hold P1 -> next_card high only in cycle 8 for one cycle; card_face updates on that edge; prev_card equals the old face.
- Correct answer: in P2, bench sends key_same if card_face==prev_card, else key_diff -> next_card the following cycle. Pulse analyse -> game_over=0, score=1, new card drawn.
- Wrong answer after 3 correct answers: send the opposite key, then analyse -> game_over=1 in the analyse cycle, high_score=3, card_valid=0 next cycle.
- Both keys together in P2 -> no pulse. Then 8 idle cycles -> next_card via timeout; analyse -> game_over=1.
- Reset mid-P2 at timer=5 -> next cycle timer=0, score=0, high_score=0, card_valid=0, next_card=0.
